// File: rtl/mod_n_counter.sv
// Parametrised modulo-N up/down counter with parallel load, wrap strobe and
// a one-shot mode that stops at the terminal value and raises a sticky done.
module mod_n_counter #(
   parameter int unsigned     WIDTH     = 8,
   parameter longint unsigned MODULUS   = 256,
   parameter longint unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             up_down,
   input  logic             one_shot,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] counter_output,
   output logic             wrap,
   output logic             done
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic             r_done;

   logic [WIDTH-1:0] w_clamped;
   logic [WIDTH-1:0] w_term;
   logic [WIDTH-1:0] w_step;
   logic             w_at_term;
   logic [WIDTH-1:0] w_next_count;
   logic             w_next_wrap;
   logic             w_next_done;

   // Out-of-range loads saturate to the top of the count range.
   assign w_clamped = ({1'b0, load_value} < MOD_EXT) ? load_value : MAX_VAL;
   assign w_term    = up_down ? MAX_VAL : '0;
   assign w_at_term = (r_count == w_term);
   assign w_step    = up_down ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));

   // Wrap is decided by comparison with the terminal value, so non-power-of-two
   // moduli never rely on natural overflow of the register width.
   always_comb begin
      w_next_count = r_count;
      w_next_wrap  = 1'b0;
      w_next_done  = r_done;
      if (load) begin
         w_next_count = w_clamped;
         w_next_done  = 1'b0;
      end else if (start && !r_done) begin
         if (one_shot) begin
            if (!w_at_term) begin
               w_next_count = w_step;
            end
            w_next_done = w_at_term || (w_step == w_term);
         end else if (w_at_term) begin
            w_next_count = up_down ? '0 : MAX_VAL;
            w_next_wrap  = 1'b1;
         end else begin
            w_next_count = w_step;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= RST_VAL;
         r_wrap  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_count <= w_next_count;
         r_wrap  <= w_next_wrap;
         r_done  <= w_next_done;
      end
   end

   assign counter_output = r_count;
   assign wrap           = r_wrap;
   assign done           = r_done;

endmodule

// File: tb/tb_mod_n_counter.sv
// Scoreboard bench: four counter instances of different geometry share one
// stimulus stream; a reference model predicts each, a monitor compares.
module tb_mod_n_counter;

   localparam int NDUT = 4;

   typedef struct packed {
      logic [8:0] cnt;
      logic       wrp;
      logic       dn;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, start, up_down, one_shot, load;
   logic [8:0] lv;

   logic [7:0] a_cnt;  logic a_wrap, a_done;
   logic [8:0] b_cnt;  logic b_wrap, b_done;
   logic [3:0] c_cnt;  logic c_wrap, c_done;
   logic [0:0] d_cnt;  logic d_wrap, d_done;

   always #5 clk = ~clk;

   mod_n_counter #(.WIDTH(8), .MODULUS(256), .RESET_VAL(0)) u_a (
      .clk(clk), .rst(rst), .start(start), .up_down(up_down), .one_shot(one_shot),
      .load(load), .load_value(lv[7:0]), .counter_output(a_cnt), .wrap(a_wrap), .done(a_done));
   mod_n_counter #(.WIDTH(9), .MODULUS(255), .RESET_VAL(5)) u_b (
      .clk(clk), .rst(rst), .start(start), .up_down(up_down), .one_shot(one_shot),
      .load(load), .load_value(lv), .counter_output(b_cnt), .wrap(b_wrap), .done(b_done));
   mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) u_c (
      .clk(clk), .rst(rst), .start(start), .up_down(up_down), .one_shot(one_shot),
      .load(load), .load_value(lv[3:0]), .counter_output(c_cnt), .wrap(c_wrap), .done(c_done));
   mod_n_counter #(.WIDTH(1), .MODULUS(2), .RESET_VAL(1)) u_d (
      .clk(clk), .rst(rst), .start(start), .up_down(up_down), .one_shot(one_shot),
      .load(load), .load_value(lv[0:0]), .counter_output(d_cnt), .wrap(d_wrap), .done(d_done));

   exp_t act [NDUT];
   assign act[0] = {1'b0, a_cnt, a_wrap, a_done};
   assign act[1] = {b_cnt, b_wrap, b_done};
   assign act[2] = {5'b0, c_cnt, c_wrap, c_done};
   assign act[3] = {8'b0, d_cnt, d_wrap, d_done};

   // Reference model state, one entry per instance.
   longint unsigned mmod [NDUT] = '{256, 255, 10, 2};
   longint unsigned mrst [NDUT] = '{0, 5, 3, 1};
   int              mwid [NDUT] = '{8, 9, 4, 1};
   longint unsigned mval [NDUT];
   bit              mwrp [NDUT];
   bit              mdn  [NDUT];

   exp_t q [NDUT][$];
   int   total = 0;
   int   bad   = 0;

   task automatic model(input int k, input bit r, input bit l, input logic [8:0] v,
                        input bit s, input bit u, input bit o);
      longint unsigned lvk, t;
      lvk = longint'(v) & ((64'd1 << mwid[k]) - 64'd1);
      t   = u ? mmod[k] - 1 : 0;
      mwrp[k] = 1'b0;
      if (r) begin
         mval[k] = mrst[k];
         mdn[k]  = 1'b0;
      end else if (l) begin
         mval[k] = (lvk < mmod[k]) ? lvk : mmod[k] - 1;
         mdn[k]  = 1'b0;
      end else if (s && !mdn[k]) begin
         if (o) begin
            if (mval[k] != t) mval[k] = u ? mval[k] + 1 : mval[k] - 1;
            mdn[k] = (mval[k] == t);
         end else begin
            mwrp[k] = (mval[k] == t);
            mval[k] = (mval[k] + mmod[k] + (u ? 1 : mmod[k] - 1)) % mmod[k];
         end
      end
   endtask

   task automatic step(input bit r, input bit l, input logic [8:0] v,
                       input bit s, input bit u, input bit o);
      @(negedge clk);
      rst = r; load = l; lv = v; start = s; up_down = u; one_shot = o;
      for (int k = 0; k < NDUT; k++) begin
         model(k, r, l, v, s, u, o);
         q[k].push_back(exp_t'{cnt: 9'(mval[k]), wrp: mwrp[k], dn: mdn[k]});
      end
   endtask

   // Monitor: outputs are valid every cycle, compare just after each edge.
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < NDUT; k++) begin
         if (q[k].size() > 0) begin
            exp_t e;
            e = q[k].pop_front();
            total++;
            if (act[k] !== e) begin
               bad++;
               $display("FAIL dut%0d t=%0t: got cnt=%0d wrap=%0b done=%0b, want cnt=%0d wrap=%0b done=%0b",
                        k, $time, act[k].cnt, act[k].wrp, act[k].dn, e.cnt, e.wrp, e.dn);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; up_down = 1'b0; one_shot = 1'b0; load = 1'b0; lv = '0;
      // reset then count down from 0
      repeat (2) step(1, 0, 0, 0, 0, 0);
      repeat (4) step(0, 0, 0, 1, 0, 0);
      // non-power-of-two wrap going up
      step(0, 1, 253, 0, 1, 0);
      repeat (4) step(0, 0, 0, 1, 1, 0);
      // one-shot down to zero, done sticky across one_shot deassert
      step(0, 1, 3, 0, 0, 1);
      repeat (6) step(0, 0, 0, 1, 0, 1);
      repeat (2) step(0, 0, 0, 1, 1, 0);
      step(0, 1, 5, 0, 0, 1);
      step(0, 0, 0, 1, 1, 1);
      // one-shot load at terminal value
      step(0, 1, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 1);
      // priority: clamped load beats start, reset beats load
      step(0, 1, 300, 1, 1, 0);
      step(1, 1, 100, 1, 1, 0);
      // direction reversal at a boundary
      step(0, 1, 9, 0, 1, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      // hold
      step(0, 1, 42, 0, 1, 0);
      repeat (5) step(0, 0, 0, 0, 1, 0);
      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         logic [8:0] v;
         case ($urandom_range(0, 3))
            0:       v = 9'($urandom_range(0, 3));
            1:       v = 9'($urandom_range(250, 260));
            2:       v = 9'($urandom_range(8, 16));
            default: v = 9'($urandom_range(0, 511));
         endcase
         step($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0, v,
              $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0);
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         total++;
         if (q[k].size() != 0) begin
            bad++;
            $display("FAIL drain dut%0d: got %0d pending, want 0", k, q[k].size());
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
